// File: rtl/rob_int.sv
// rob_int: integer reorder buffer feeding the integer register file write port.
// Accepts in-order allocations and out-of-order completions, and retires at
// most one entry per cycle in program order. x0 is never written.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   flush                    synchronous squash of all entries
//   alloc_valid/has_rd/rd    allocation request from dispatch
//   alloc_ready, alloc_tag   combinational: entry free, tag granted (tail index)
//   cmpl_valid/tag/data      completion from execute
//   wr_enable/addr/data      registered register-file write port
//   empty, count             combinational occupancy
module rob_int #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic [31:0]      cmpl_data,
  output logic             wr_enable,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             empty,
  output logic [TAG_W:0]   count
);

  localparam int unsigned PTR_W = TAG_W + 1;

  // Control state (reset) and payload state (no reset; qualified by ent_valid)
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_has_rd;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;

  logic full_c;
  logic alloc_fire_c;
  logic cmpl_fire_c;
  logic retire_c;

  // Occupancy and handshake; the wrap bit keeps full and empty distinct
  assign head_idx     = head[TAG_W-1:0];
  assign tail_idx     = tail[TAG_W-1:0];
  assign count        = tail - head;
  assign full_c       = (count == PTR_W'(DEPTH));
  assign empty        = (count == '0);
  assign alloc_ready  = !full_c;
  assign alloc_tag    = tail_idx;
  assign alloc_fire_c = alloc_valid && alloc_ready;
  assign cmpl_fire_c  = cmpl_valid && ent_valid[cmpl_tag];
  assign retire_c     = ent_valid[head_idx] && ent_done[head_idx];

  // Pointers, valid/done bits and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      wr_enable <= 1'b0;
    end else begin
      wr_enable <= retire_c && ent_has_rd[head_idx] && (ent_rd[head_idx] != 5'd0);
      if (retire_c) begin
        wr_addr             <= ent_rd[head_idx];
        wr_data             <= ent_data[head_idx];
        ent_valid[head_idx] <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (cmpl_fire_c) begin
        ent_done[cmpl_tag] <= 1'b1;
      end
      // Allocation never targets the retiring head (that would need full) or
      // a valid completing entry, so applying it last is safe
      if (alloc_fire_c) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= 1'b0;
        tail                <= tail + PTR_W'(1);
      end
    end
  end

  // Entry payload capture
  always_ff @(posedge clk) begin
    if (alloc_fire_c) begin
      ent_has_rd[tail_idx] <= alloc_has_rd;
      ent_rd[tail_idx]     <= alloc_rd;
    end
    if (cmpl_fire_c) begin
      ent_data[cmpl_tag] <= cmpl_data;
    end
  end

endmodule

// File: tb/tb_rob_int.sv
// tb_rob_int: scenario bench for rob_int with a write scoreboard.
module tb_rob_int;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             alloc_valid;
  logic             alloc_has_rd;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cmpl_valid;
  logic [TAG_W-1:0] cmpl_tag;
  logic [31:0]      cmpl_data;
  logic             wr_enable;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             empty;
  logic [TAG_W:0]   count;

  rob_int #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int writes_seen = 0;
  logic [36:0] exp_q [$];
  logic [36:0] sb_exp;

  // Scoreboard: every register-file write must match the next expected one
  always @(negedge clk) begin
    if (!rst && wr_enable) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got x%0d=%h, required no write", wr_addr, wr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== sb_exp)
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h",
                   wr_addr, wr_data, sb_exp[36:32], sb_exp[31:0]);
        else
          passes++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // One cycle of stimulus, applied at a negedge and removed at the next
  task automatic drive(input logic av, input logic hr, input logic [4:0] rd,
                       input logic cv, input logic [TAG_W-1:0] ct, input logic [31:0] cd,
                       output logic [TAG_W-1:0] tag);
    alloc_valid  = av;
    alloc_has_rd = hr;
    alloc_rd     = rd;
    cmpl_valid   = cv;
    cmpl_tag     = ct;
    cmpl_data    = cd;
    #1 tag = alloc_tag;
    @(negedge clk);
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (empty !== 1'b1) $display("FAIL wait_empty: got empty=%b count=%0d, required drained", empty, count);
    else passes++;
  endtask

  task automatic test_reset();
    logic [TAG_W-1:0] t;
    checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b, required 1", empty); else passes++;
    checks++; if (count !== 4'd0) $display("FAIL rst_count: got %0d, required 0", count); else passes++;
    checks++; if (alloc_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", alloc_ready); else passes++;
    checks++; if (wr_enable !== 1'b0) $display("FAIL rst_wr_en: got %b, required 0", wr_enable); else passes++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 5'(i + 1), 1'b0, '0, '0, t);
    checks++; if (count !== 4'd5) $display("FAIL rst_pre_count: got %0d, required 5", count); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) $display("FAIL rst_mid_empty: got %b, required 1", empty); else passes++;
    checks++; if (count !== 4'd0) $display("FAIL rst_mid_count: got %0d, required 0", count); else passes++;
    checks++; if (wr_enable !== 1'b0) $display("FAIL rst_mid_wr_en: got %b, required 0", wr_enable); else passes++;
    checks++; if (alloc_tag !== 3'd0) $display("FAIL rst_mid_tag: got %0d, required 0", alloc_tag); else passes++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 5'd9, 1'b0, '0, '0, t);
    checks++; if (t !== 3'd0) $display("FAIL rst_first_tag: got %0d, required 0", t); else passes++;
    drive(1'b0, 1'b0, '0, 1'b1, t, 32'hDEAD, t);
    wait_empty(10);
  endtask

  task automatic test_inorder();
    logic [TAG_W-1:0] t0, t1, td;
    drive(1'b1, 1'b1, 5'd3, 1'b0, '0, '0, t0);
    exp_q.push_back({5'd3, 32'h1234});
    drive(1'b1, 1'b1, 5'd5, 1'b0, '0, '0, t1);
    exp_q.push_back({5'd5, 32'hAAAA});
    drive(1'b0, 1'b0, '0, 1'b1, t1, 32'hAAAA, td);
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_enable !== 1'b0) $display("FAIL ino_early_write: got wr_enable=%b, required 0", wr_enable); else passes++;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, 1'b1, t0, 32'h1234, td);
    checks++; if (wr_enable !== 1'b0) $display("FAIL ino_latency: got wr_enable=%b, required 0", wr_enable); else passes++;
    @(negedge clk);
    checks++;
    if ({wr_enable, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h1234})
      $display("FAIL ino_first: got en=%b x%0d=%h, required en=1 x3=00001234", wr_enable, wr_addr, wr_data);
    else passes++;
    @(negedge clk);
    checks++;
    if ({wr_enable, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hAAAA})
      $display("FAIL ino_second: got en=%b x%0d=%h, required en=1 x5=0000aaaa", wr_enable, wr_addr, wr_data);
    else passes++;
    @(negedge clk);
    checks++; if (empty !== 1'b1) $display("FAIL ino_empty: got %b, required 1", empty); else passes++;
  endtask

  task automatic test_x0_nord();
    logic [TAG_W-1:0] ta, tb, td;
    drive(1'b1, 1'b1, 5'd0, 1'b0, '0, '0, ta);
    drive(1'b1, 1'b0, 5'd7, 1'b0, '0, '0, tb);
    drive(1'b0, 1'b0, '0, 1'b1, ta, 32'h5555, td);
    drive(1'b0, 1'b0, '0, 1'b1, tb, 32'h7777, td);
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_enable !== 1'b0) $display("FAIL x0_wr_en: got %b, required 0", wr_enable); else passes++;
      @(negedge clk);
    end
    checks++; if (count !== 4'd0) $display("FAIL x0_count: got %0d, required 0", count); else passes++;
  endtask

  task automatic test_full_wrap();
    logic [TAG_W-1:0] t;
    int w0;
    do_flush();
    w0 = writes_seen;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 1'b0, '0, '0, t);
      exp_q.push_back({5'(i + 1), 32'h100 + 32'(i)});
      checks++; if (t !== 3'(i)) $display("FAIL full_tag%0d: got %0d, required %0d", i, t, i); else passes++;
    end
    checks++; if (alloc_ready !== 1'b0) $display("FAIL full_ready: got %b, required 0", alloc_ready); else passes++;
    checks++; if (count !== 4'd8) $display("FAIL full_count: got %0d, required 8", count); else passes++;
    drive(1'b1, 1'b1, 5'd30, 1'b0, '0, '0, t);
    checks++; if (count !== 4'd8) $display("FAIL full_refuse: got count=%0d, required 8", count); else passes++;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 3'(i), 32'h100 + 32'(i), t);
    repeat (3) @(negedge clk);
    checks++; if (count !== 4'd5) $display("FAIL wrap_count: got %0d, required 5", count); else passes++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i + 9), 1'b0, '0, '0, t);
      exp_q.push_back({5'(i + 9), 32'h200 + 32'(i)});
      checks++; if (t !== 3'(i)) $display("FAIL wrap_tag%0d: got %0d, required %0d", i, t, i); else passes++;
    end
    checks++; if (count !== 4'd8) $display("FAIL wrap_full: got %0d, required 8", count); else passes++;
    for (int i = 3; i < 8; i++) drive(1'b0, 1'b0, '0, 1'b1, 3'(i), 32'h100 + 32'(i), t);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 3'(i), 32'h200 + 32'(i), t);
    wait_empty(20);
    @(negedge clk);
    checks++; if (writes_seen - w0 !== 11) $display("FAIL wrap_writes: got %0d, required 11", writes_seen - w0); else passes++;
  endtask

  task automatic test_simultaneous();
    logic [TAG_W-1:0] ta, tb, tc, td;
    drive(1'b1, 1'b1, 5'd12, 1'b0, '0, '0, ta);
    checks++; if (ta !== 3'd3) $display("FAIL sim_start_tag: got %0d, required 3", ta); else passes++;
    exp_q.push_back({5'd12, 32'hC0C0});
    drive(1'b1, 1'b1, 5'd13, 1'b1, ta, 32'hC0C0, tb);
    exp_q.push_back({5'd13, 32'hD0D0});
    checks++; if (count !== 4'd2) $display("FAIL sim_pre_count: got %0d, required 2", count); else passes++;
    // head ta retires, tb completes and tc allocates at the same edge
    drive(1'b1, 1'b1, 5'd14, 1'b1, tb, 32'hD0D0, tc);
    exp_q.push_back({5'd14, 32'hE0E0});
    checks++; if (count !== 4'd2) $display("FAIL sim_count: got %0d, required 2", count); else passes++;
    checks++; if (tc !== 3'(ta + 3'd2)) $display("FAIL sim_tag: got %0d, required %0d", tc, 3'(ta + 3'd2)); else passes++;
    drive(1'b0, 1'b0, '0, 1'b1, tc, 32'hE0E0, td);
    wait_empty(10);
  endtask

  task automatic test_flush();
    logic [TAG_W-1:0] f [4];
    logic [TAG_W-1:0] t;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 5'(20 + i), 1'b0, '0, '0, f[i]);
    drive(1'b0, 1'b0, '0, 1'b1, f[2], 32'h22, t);
    drive(1'b0, 1'b0, '0, 1'b1, f[3], 32'h33, t);
    checks++; if (count !== 4'd4) $display("FAIL fl_pre_count: got %0d, required 4", count); else passes++;
    do_flush();
    checks++; if (empty !== 1'b1) $display("FAIL fl_empty: got %b, required 1", empty); else passes++;
    checks++; if (wr_enable !== 1'b0) $display("FAIL fl_wr_en: got %b, required 0", wr_enable); else passes++;
    drive(1'b0, 1'b0, '0, 1'b1, f[0], 32'h44, t);
    drive(1'b0, 1'b0, '0, 1'b1, f[1], 32'h55, t);
    repeat (2) @(negedge clk);
    checks++; if (count !== 4'd0) $display("FAIL fl_stale_cmpl: got count=%0d, required 0", count); else passes++;
    drive(1'b1, 1'b1, 5'd25, 1'b0, '0, '0, t);
    checks++; if (t !== 3'd0) $display("FAIL fl_tag: got %0d, required 0", t); else passes++;
    exp_q.push_back({5'd25, 32'h99});
    drive(1'b0, 1'b0, '0, 1'b1, t, 32'h99, t);
    wait_empty(10);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0;
    cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_inorder();
    test_x0_nord();
    test_full_wrap();
    test_simultaneous();
    test_flush();
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
